// File: rtl/uart_pkg.sv
// Shared types and register map for the user UART receiver.
// Optional even-parity support is enabled with USER_UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [2:0] UART_RX_DATA_OFS = 3'd0;
  localparam logic [2:0] UART_RX_STAT_OFS = 3'd4;

  localparam int OVF_BIT  = 8;
  localparam int FERR_BIT = 9;
  localparam int PERR_BIT = 10;

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with wrap pointers, occupancy count and
// a drop strobe for pushes that find no free slot.
module uart_rx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count,
  output logic                 drop
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [DEPTH_LOG-1:0] wp_q, wp_d;
  logic [DEPTH_LOG-1:0] rp_q, rp_d;
  logic [DEPTH_LOG:0]   cnt_q, cnt_d;
  logic                 do_push;
  logic                 do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rp_q];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + 1'b1;
    end
    if (do_pop) begin
      rp_d = rp_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/user_uart_rx.sv
// naive_bus slave that deserialises 8N1 frames into an RX FIFO.
// Define USER_UART_RX_PARITY_EN for 8E1 frames with a sticky perr flag.
module user_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV        = 434,
  parameter int FIFO_DEPTH_LOG = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_uart_rx,
  input  logic        rd_req,
  output logic        rd_gnt,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  output logic        wr_gnt,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data
);

  localparam logic [15:0] FULL_RL = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_RL = 16'(CLK_DIV / 2 - 1);

  rx_state_t   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        brk_q, brk_d;
  logic        ovf_q, ovf_d;
  logic        ferr_q, ferr_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        rx_s;
  logic        tc;
  logic        fifo_push;
  logic        set_ferr;
  logic        fifo_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [FIFO_DEPTH_LOG:0] fifo_count;
  logic        fifo_drop;
  logic        rd_stat;
  logic        wr_clr;
  logic [31:0] stat;
  logic        unused_ok;

`ifdef USER_UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        perr_q, perr_d;
  logic        set_perr;
`endif

  assign sync_d = {sync_q[0], i_uart_rx};
  assign rx_s   = sync_q[1];
  assign tc     = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!brk_q && !rx_s) state_d = START;
      end
      START: begin
        if (tc) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tc && bit_q == 3'd7) begin
`ifdef USER_UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef USER_UART_RX_PARITY_EN
      PARITY: begin
        if (tc) state_d = STOP;
      end
`endif
      STOP: begin
        if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_push = 1'b0;
    set_ferr  = 1'b0;
`ifdef USER_UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    set_perr  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!brk_q && !rx_s) cnt_d = HALF_RL;
      end
      START: begin
        cnt_d = tc ? FULL_RL : cnt_q - 1'b1;
        if (tc) bit_d = '0;
      end
      DATA: begin
        cnt_d = tc ? FULL_RL : cnt_q - 1'b1;
        if (tc) begin
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 1'b1;
        end
      end
`ifdef USER_UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = tc ? FULL_RL : cnt_q - 1'b1;
        if (tc) begin
          par_bad_d = (rx_s != even_par(shift_q));
          set_perr  = par_bad_d;
        end
      end
`endif
      STOP: begin
        if (!tc) cnt_d = cnt_q - 1'b1;
        if (tc) begin
`ifdef USER_UART_RX_PARITY_EN
          fifo_push = rx_s && !par_bad_q;
`else
          fifo_push = rx_s;
`endif
          set_ferr  = !rx_s;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // After a bad stop bit the line may sit in break; rearm only once high.
  always_comb begin
    brk_d = brk_q;
    if (set_ferr) brk_d = 1'b1;
    else if (rx_s) brk_d = 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH    (8),
    .DEPTH_LOG(FIFO_DEPTH_LOG)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(shift_q),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count),
    .drop (fifo_drop)
  );

  assign rd_gnt   = rd_req;
  assign wr_gnt   = wr_req;
  assign rd_stat  = (rd_addr[2] == UART_RX_STAT_OFS[2]);
  assign fifo_pop = rd_req && (rd_addr[2] == UART_RX_DATA_OFS[2]);
  assign wr_clr   = wr_req && (wr_addr[2] == UART_RX_STAT_OFS[2])
                    && wr_be[1];

  always_comb begin
    stat                     = '0;
    stat[FIFO_DEPTH_LOG:0]   = fifo_count;
    stat[OVF_BIT]            = ovf_q;
    stat[FERR_BIT]           = ferr_q;
`ifdef USER_UART_RX_PARITY_EN
    stat[PERR_BIT]           = perr_q;
`endif
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_req) begin
      if (rd_stat) rd_data_d = stat;
      else if (fifo_empty) rd_data_d = '0;
      else rd_data_d = {23'b0, 1'b1, fifo_rdata};
    end
  end

  // A set in the same cycle as its clear wins.
  always_comb begin
    ovf_d  = fifo_drop | (ovf_q & ~(wr_clr & wr_data[OVF_BIT]));
    ferr_d = set_ferr | (ferr_q & ~(wr_clr & wr_data[FERR_BIT]));
`ifdef USER_UART_RX_PARITY_EN
    perr_d = set_perr | (perr_q & ~(wr_clr & wr_data[PERR_BIT]));
`endif
  end

  assign rd_data = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef USER_UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
`endif

  assign unused_ok = ^{rd_addr, wr_addr, wr_be, wr_data, fifo_full};

endmodule

// File: tb/tb_user_uart_rx.sv
// Scoreboard bench for user_uart_rx: directed frames, bus reads
// checked by an independent monitor against queued expectations.
module tb_user_uart_rx;

  localparam int CLK_DIV = 64;
  localparam logic [31:0] BASE = 32'h0003_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_uart_rx = 1'b1;
  logic        rd_req = 1'b0;
  logic        rd_gnt;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        wr_req = 1'b0;
  logic        wr_gnt;
  logic [31:0] wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #10 clk = ~clk;

  user_uart_rx #(
    .CLK_DIV       (CLK_DIV),
    .FIFO_DEPTH_LOG(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_uart_rx(i_uart_rx),
    .rd_req   (rd_req),
    .rd_gnt   (rd_gnt),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_gnt   (wr_gnt),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  initial begin
    forever begin
      @(posedge clk);
      if (rd_gnt) begin
        #1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read got=%08h want=none", rd_data);
        end else begin
          logic [31:0] e;
          string t;
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (rd_data !== e) begin
            failures++;
            $display("FAIL %s got=%08h want=%08h", t, rd_data, e);
          end
        end
      end
    end
  end

  task automatic check(input logic [31:0] got, input logic [31:0] want,
                       input string t);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%08h want=%08h", t, got, want);
    end
  endtask

  task automatic send_bit(input logic b);
    i_uart_rx = b;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef USER_UART_RX_PARITY_EN
    send_bit((^b) ^ bad_par);
`else
    if (bad_par) $display("note: parity ignored in 8N1 build");
`endif
    send_bit(stop);
    i_uart_rx = 1'b1;
  endtask

  task automatic bus_read(input logic stat, input logic [31:0] e,
                          input string t);
    rd_addr = BASE | {29'b0, stat, 2'b00};
    rd_req  = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    rd_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic stat, input logic [3:0] be,
                           input logic [31:0] d);
    wr_addr = BASE | {29'b0, stat, 2'b00};
    wr_be   = be;
    wr_data = d;
    wr_req  = 1'b1;
    @(negedge clk);
    wr_req  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    check(rd_data, 32'h0, "reset_rd_data");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(1'b1, 32'h0, "reset_status");

    // single frame
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (CLK_DIV) @(negedge clk);
    bus_read(1'b0, 32'h0000_01A5, "data_a5");
    bus_read(1'b0, 32'h0, "data_empty");
    bus_read(1'b1, 32'h0, "status_after_a5");

    // overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 1'b0);
    repeat (CLK_DIV) @(negedge clk);
    bus_read(1'b1, 32'h0000_0110, "status_ovf_full");
    bus_write(1'b1, 4'b0010, 32'h0000_0100);
    bus_read(1'b1, 32'h0000_0010, "status_ovf_cleared");

    // read from a full FIFO in the cycle the next byte lands
    hit = 1'b0;
    fork
      send_byte(8'h77, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 20 * CLK_DIV && !hit; k++) begin
          @(negedge clk);
          if (dut.fifo_push) begin
            hit     = 1'b1;
            rd_addr = BASE;
            rd_req  = 1'b1;
            exp_q.push_back(32'h0000_0100);
            tag_q.push_back("data_simul_pop");
            @(negedge clk);
            rd_req  = 1'b0;
          end
        end
      end
    join
    check({31'b0, hit}, 32'h1, "simul_push_seen");
    repeat (CLK_DIV) @(negedge clk);
    bus_read(1'b1, 32'h0000_0010, "status_simul");
    for (int i = 1; i < 16; i++)
      bus_read(1'b0, 32'h0000_0100 | 32'(i), "data_drain");
    bus_read(1'b0, 32'h0000_0177, "data_last_77");
    bus_read(1'b0, 32'h0, "data_drained_empty");
    bus_read(1'b1, 32'h0, "status_drained");

    // framing error, write to DATA ignored, clear via STATUS
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    bus_read(1'b1, 32'h0000_0200, "status_ferr");
    bus_write(1'b0, 4'b1111, 32'h0000_0200);
    bus_read(1'b1, 32'h0000_0200, "status_ferr_data_wr");
    bus_write(1'b1, 4'b0001, 32'h0000_0200);
    bus_read(1'b1, 32'h0000_0200, "status_ferr_wrong_be");
    bus_write(1'b1, 4'b0010, 32'h0000_0200);
    bus_read(1'b1, 32'h0, "status_ferr_cleared");

    // short glitch
    i_uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    i_uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check({29'b0, dut.state_q}, {29'b0, uart_pkg::IDLE}, "glitch_idle");
    bus_read(1'b1, 32'h0, "status_glitch");
    bus_read(1'b0, 32'h0, "data_glitch");

    // reset during data bit 4 of 0x5A (line high there)
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b0);
    i_uart_rx = 1'b1;
    repeat (CLK_DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check({29'b0, dut.state_q}, {29'b0, uart_pkg::IDLE}, "reset_mid_idle");
    bus_read(1'b1, 32'h0, "status_reset_mid");
    send_byte(8'h5A, 1'b1, 1'b0);
    repeat (CLK_DIV) @(negedge clk);
    bus_read(1'b0, 32'h0000_015A, "data_5a");
    bus_read(1'b1, 32'h0, "status_after_5a");

`ifdef USER_UART_RX_PARITY_EN
    send_byte(8'h01, 1'b1, 1'b1);
    repeat (CLK_DIV) @(negedge clk);
    bus_read(1'b1, 32'h0000_0400, "status_perr");
    bus_write(1'b1, 4'b0010, 32'h0000_0400);
    bus_read(1'b1, 32'h0, "status_perr_cleared");
    send_byte(8'h03, 1'b1, 1'b0);
    repeat (CLK_DIV) @(negedge clk);
    bus_read(1'b0, 32'h0000_0103, "data_par_ok");
`endif

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
